// File: rtl/acq_sched_pkg.sv
// Shared types and constants for the CPMG acquisition-window scheduler.
// State encoding is one-hot; the config check reduces to a single ok/bad bit.
package acq_sched_pkg;

    localparam int unsigned MIN_GAP_DEFAULT = 2;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_DLY     = 5'b00010,
        ST_WND_ON  = 5'b00100,
        ST_WND_OFF = 5'b01000,
        ST_FINISH  = 5'b10000
    } state_t;

    localparam logic CFG_OK  = 1'b1;
    localparam logic CFG_BAD = 1'b0;

endpackage

// File: rtl/acq_period_timer.sv
// Loadable down-counter timing each scheduler phase; load wins over enable.
// Terminal flag is ==0 on the registered count; the count saturates at zero.
module acq_period_timer #(
    parameter int TIME_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  i_load,
    input  logic [TIME_WIDTH-1:0] i_load_val,
    input  logic                  i_en,
    output logic                  o_zero
);

    logic [TIME_WIDTH-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TIME_WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/acq_echo_scheduler.sv
// Generates N ACQ_WND pulses per CPMG scan (first-echo delay, spacing, window length).
// All outputs registered; START sampled only in IDLE, ABORT cancels on the next edge.
module acq_echo_scheduler
    import acq_sched_pkg::*;
#(
    parameter int          ECHO_CNT_WIDTH = 16,
    parameter int          TIME_WIDTH     = 32,
    parameter int unsigned MIN_GAP        = MIN_GAP_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic                      ABORT,
    input  logic [ECHO_CNT_WIDTH-1:0] ECHOES_PER_SCAN,
    input  logic [TIME_WIDTH-1:0]     FIRST_ECHO_DELAY,
    input  logic [TIME_WIDTH-1:0]     ECHO_SPACING,
    input  logic [TIME_WIDTH-1:0]     ACQ_WND_LEN,
    output logic                      ACQ_WND,
    output logic [ECHO_CNT_WIDTH-1:0] ECHO_IDX,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      CFG_ERR
);

    state_t                    r_state;
    logic                      r_acq_wnd;
    logic [ECHO_CNT_WIDTH-1:0] r_echo_idx;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_cfg_err;
    logic [ECHO_CNT_WIDTH-1:0] r_echoes;
    logic [TIME_WIDTH-1:0]     r_spacing;
    logic [TIME_WIDTH-1:0]     r_len;

    logic                      w_cfg_ok;
    logic [TIME_WIDTH:0]       w_gap_need;
    logic                      w_last;
    logic                      w_tmr_load;
    logic [TIME_WIDTH-1:0]     w_tmr_val;
    logic                      w_tmr_en;
    logic                      w_tmr_zero;

    // One extra bit so a huge window length cannot wrap past the spacing check.
    assign w_gap_need = {1'b0, ACQ_WND_LEN} + (TIME_WIDTH+1)'(MIN_GAP);
    assign w_cfg_ok   = ((ECHOES_PER_SCAN != '0) && (FIRST_ECHO_DELAY != '0) &&
                         (ACQ_WND_LEN != '0) && (w_gap_need <= {1'b0, ECHO_SPACING}))
                        ? CFG_OK : CFG_BAD;
    assign w_last     = (r_echo_idx == (r_echoes - ECHO_CNT_WIDTH'(1)));

    // Each phase loads (length - 1) so the terminal edge lands exactly on the boundary.
    // The first delay is captured straight into the timer at START, so it needs no shadow copy.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START && !ABORT && (w_cfg_ok == CFG_OK)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = FIRST_ECHO_DELAY - TIME_WIDTH'(1);
                end
            end
            ST_DLY, ST_WND_OFF: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = r_len - TIME_WIDTH'(1);
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_WND_ON: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = r_spacing - r_len - TIME_WIDTH'(1);
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    acq_period_timer #(
        .TIME_WIDTH (TIME_WIDTH)
    ) u_timer (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_acq_wnd  <= 1'b0;
            r_echo_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_echoes   <= '0;
            r_spacing  <= '0;
            r_len      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if ((r_state != ST_IDLE) && ABORT) begin
                r_state   <= ST_IDLE;
                r_acq_wnd <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (START && !ABORT) begin
                            if (w_cfg_ok == CFG_OK) begin
                                r_echoes   <= ECHOES_PER_SCAN;
                                r_spacing  <= ECHO_SPACING;
                                r_len      <= ACQ_WND_LEN;
                                r_echo_idx <= '0;
                                r_busy     <= 1'b1;
                                r_state    <= ST_DLY;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_DLY: begin
                        if (w_tmr_zero) begin
                            r_acq_wnd  <= 1'b1;
                            r_echo_idx <= '0;
                            r_state    <= ST_WND_ON;
                        end
                    end
                    ST_WND_ON: begin
                        if (w_tmr_zero) begin
                            r_acq_wnd <= 1'b0;
                            r_state   <= w_last ? ST_FINISH : ST_WND_OFF;
                        end
                    end
                    ST_WND_OFF: begin
                        if (w_tmr_zero) begin
                            r_acq_wnd  <= 1'b1;
                            r_echo_idx <= r_echo_idx + ECHO_CNT_WIDTH'(1);
                            r_state    <= ST_WND_ON;
                        end
                    end
                    ST_FINISH: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ACQ_WND  = r_acq_wnd;
    assign ECHO_IDX = r_echo_idx;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign CFG_ERR  = r_cfg_err;

endmodule

// File: tb/tb_acq_echo_scheduler.sv
// Scoreboard bench: stimulus pushes expected output events (edge number, kind, index)
// computed from the scan timing rules; a negedge monitor pops and compares them.
module tb_acq_echo_scheduler;

    localparam int EW = 16;
    localparam int TW = 32;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_BUP  = 2;
    localparam int EV_BDN  = 3;
    localparam int EV_DONE = 4;
    localparam int EV_CERR = 5;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [EW-1:0] ECHOES_PER_SCAN = '0;
    logic [TW-1:0] FIRST_ECHO_DELAY = '0;
    logic [TW-1:0] ECHO_SPACING = '0;
    logic [TW-1:0] ACQ_WND_LEN = '0;
    logic          ACQ_WND;
    logic [EW-1:0] ECHO_IDX;
    logic          BUSY;
    logic          DONE;
    logic          CFG_ERR;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;
    ev_t  exp_q[$];
    logic p_wnd = 1'b0;
    logic p_busy = 1'b0;

    acq_echo_scheduler #(
        .ECHO_CNT_WIDTH (EW),
        .TIME_WIDTH     (TW)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .START            (START),
        .ABORT            (ABORT),
        .ECHOES_PER_SCAN  (ECHOES_PER_SCAN),
        .FIRST_ECHO_DELAY (FIRST_ECHO_DELAY),
        .ECHO_SPACING     (ECHO_SPACING),
        .ACQ_WND_LEN      (ACQ_WND_LEN),
        .ACQ_WND          (ACQ_WND),
        .ECHO_IDX         (ECHO_IDX),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .CFG_ERR          (CFG_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int idx);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind, input int idx);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL event: got kind %0d at cycle %0d idx %0d, expected no event", kind, cyc, idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.idx != idx) begin
                n_errs++;
                $display("FAIL event: got kind %0d at cycle %0d idx %0d, expected kind %0d at cycle %0d idx %0d",
                         kind, cyc, idx, e.kind, e.cyc, e.idx);
            end
        end
    endtask

    // Monitor: fixed intra-cycle order RISE, FALL, BUSY up, BUSY down, DONE, CFG_ERR.
    always @(negedge CLK) begin
        if (ACQ_WND && !p_wnd) see(EV_RISE, int'(ECHO_IDX));
        if (!ACQ_WND && p_wnd) see(EV_FALL, 0);
        if (BUSY && !p_busy)   see(EV_BUP, 0);
        if (!BUSY && p_busy)   see(EV_BDN, 0);
        if (DONE)              see(EV_DONE, int'(ECHO_IDX));
        if (CFG_ERR)           see(EV_CERR, 0);
        p_wnd  = ACQ_WND;
        p_busy = BUSY;
    end

    // Reference: window i rises at k+D+i*SP and lasts LEN edges; DONE one edge after the
    // last fall. A cut at edge a (abort, or reset seen at a) drops everything from a on.
    task automatic model_scan(input int k, input int e, input int d, input int sp,
                              input int len, input int a);
        int  lim;
        int  r;
        int  f;
        bit  high;
        lim  = (a > 0) ? a : 32'h3fff_ffff;
        high = 1'b0;
        push(EV_BUP, k, 0);
        for (int i = 0; i < e; i++) begin
            r = k + d + i * sp;
            if (r >= lim) break;
            push(EV_RISE, r, i);
            if (r + len < lim) push(EV_FALL, r + len, 0);
            else high = 1'b1;
        end
        if (a > 0) begin
            if (high) push(EV_FALL, a, 0);
            push(EV_BDN, a, 0);
        end else begin
            f = k + d + (e - 1) * sp + len;
            push(EV_BDN, f + 1, 0);
            push(EV_DONE, f + 1, e - 1);
        end
    endtask

    task automatic run_scan(input int e, input longint d, input longint sp, input longint len,
                            input int abort_off, input bit noise);
        int k;
        int f;
        int a;
        int endc;
        bit valid;
        @(negedge CLK);
        ECHOES_PER_SCAN  = EW'(e);
        FIRST_ECHO_DELAY = TW'(d);
        ECHO_SPACING     = TW'(sp);
        ACQ_WND_LEN      = TW'(len);
        START = 1'b1;
        ABORT = 1'b0;
        k = cyc + 1;
        valid = (e >= 1) && (d >= 1) && (len >= 1) && (len + 2 <= sp);
        if (!valid) begin
            push(EV_CERR, k, 0);
            @(negedge CLK);
            START = 1'b0;
            repeat (2) @(negedge CLK);
            return;
        end
        f = k + int'(d) + (e - 1) * int'(sp) + int'(len);
        a = (abort_off > 0) ? k + abort_off : 0;
        model_scan(k, e, int'(d), int'(sp), int'(len), a);
        @(negedge CLK);
        START = 1'b0;
        endc = (a > 0) ? a : f + 1;
        while (cyc < endc) begin
            ABORT = (a > 0) && (cyc + 1 == a);
            START = noise && (cyc + 1 <= f) && (a == 0 || cyc + 1 < a) && ($urandom_range(0, 3) == 0);
            if (noise && $urandom_range(0, 3) == 0) begin
                ECHO_SPACING     = TW'($urandom);
                ACQ_WND_LEN      = TW'($urandom_range(0, 20));
                FIRST_ECHO_DELAY = TW'($urandom_range(0, 20));
                ECHOES_PER_SCAN  = EW'($urandom_range(0, 9));
            end
            @(negedge CLK);
        end
        ABORT = 1'b0;
        START = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish, expected finish within budget");
        n_errs++;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int k1;
        int k2;
        int f2;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("reset ACQ_WND", longint'(ACQ_WND), 0);
        chk("reset ECHO_IDX", longint'(ECHO_IDX), 0);
        chk("reset BUSY", longint'(BUSY), 0);
        chk("reset DONE", longint'(DONE), 0);
        chk("reset CFG_ERR", longint'(CFG_ERR), 0);

        run_scan(3, 5, 10, 4, 0, 1'b0);               // basic timing
        run_scan(1, 1, 3, 1, 0, 1'b0);                // minimum case
        run_scan(3, 5, 10, 9, 0, 1'b0);               // gap below minimum
        run_scan(0, 5, 10, 4, 0, 1'b0);               // zero echoes
        run_scan(3, 5, 10, 0, 0, 1'b0);               // zero window length
        run_scan(3, 0, 10, 4, 0, 1'b0);               // zero first delay
        run_scan(2, 3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1'b0); // len+gap overflows TW bits
        run_scan(3, 5, 10, 4, 16, 1'b0);              // abort inside second window
        run_scan(3, 5, 10, 4, 0, 1'b1);               // mid-scan START / config churn
        run_scan(65535, 1, 3, 1, 20, 1'b0);           // largest echo count, then abort

        // START and ABORT together in IDLE: nothing starts.
        @(negedge CLK);
        ECHOES_PER_SCAN = 2; FIRST_ECHO_DELAY = 2; ECHO_SPACING = 8; ACQ_WND_LEN = 3;
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        chk("start+abort BUSY", longint'(BUSY), 0);
        chk("start+abort CFG_ERR", longint'(CFG_ERR), 0);
        repeat (4) @(negedge CLK);
        chk("start+abort ACQ_WND", longint'(ACQ_WND), 0);

        // Reset asserted while the first window is high.
        @(negedge CLK);
        ECHOES_PER_SCAN = 2; FIRST_ECHO_DELAY = 3; ECHO_SPACING = 10; ACQ_WND_LEN = 6;
        START = 1'b1;
        k = cyc + 1;
        model_scan(k, 2, 3, 10, 6, k + 5);
        @(negedge CLK);
        START = 1'b0;
        while (cyc < k + 4) @(negedge CLK);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("async reset ACQ_WND", longint'(ACQ_WND), 0);
        chk("async reset BUSY", longint'(BUSY), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("post-reset ACQ_WND", longint'(ACQ_WND), 0);
        chk("post-reset ECHO_IDX", longint'(ECHO_IDX), 0);
        chk("post-reset BUSY", longint'(BUSY), 0);
        chk("post-reset DONE", longint'(DONE), 0);
        chk("post-reset CFG_ERR", longint'(CFG_ERR), 0);

        // Back-to-back scans with START held high across DONE.
        @(negedge CLK);
        ECHOES_PER_SCAN = 2; FIRST_ECHO_DELAY = 2; ECHO_SPACING = 8; ACQ_WND_LEN = 3;
        START = 1'b1;
        k1 = cyc + 1;
        k2 = k1 + 2 + 8 + 3 + 2;
        f2 = k2 + 2 + 8 + 3;
        model_scan(k1, 2, 2, 8, 3, 0);
        model_scan(k2, 2, 2, 8, 3, 0);
        while (cyc < k2) @(negedge CLK);
        START = 1'b0;
        while (cyc < f2 + 3) @(negedge CLK);

        for (int t = 0; t < 30; t++) begin
            int     e;
            int     ab;
            longint d;
            longint sp;
            longint len;
            e   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            d   = longint'($urandom_range(0, 6));
            len = longint'($urandom_range(0, 5));
            sp  = longint'($urandom_range(1, 12));
            ab  = 0;
            if (e >= 1 && d >= 1 && len >= 1 && len + 2 <= sp && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, int'(d) + (e - 1) * int'(sp) + int'(len) + 1));
            run_scan(e, d, sp, len, ab, 1'(($urandom_range(0, 1))));
        end

        repeat (5) @(negedge CLK);
        chk("pending expected events", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
